dense_output_layer: RTL and testbench



---
 rtl/nn_pkg.sv | 33 +++
 rtl/mac_unit.sv | 38 +++
 rtl/dense_output_layer.sv | 190 +++++++++++++++++++
 tb/tb_dense_output_layer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared widths, sizes, FSM states and logit saturation for the MNIST dense layers
package nn_pkg;

  localparam int DATA_W    = 16;
  localparam int W_W       = 16;
  localparam int ACC_W     = 40;
  localparam int LOGIT_W   = 32;
  localparam int N_HIDDEN  = 32;
  localparam int N_CLASSES = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_ARGMAX,
    S_DONE
  } state_t;

  localparam logic signed [ACC_W-1:0] LOGIT_MAX_EXT =
    {{(ACC_W-LOGIT_W+1){1'b0}}, {(LOGIT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] LOGIT_MIN_EXT =
    {{(ACC_W-LOGIT_W+1){1'b1}}, {(LOGIT_W-1){1'b0}}};

  // Clamp a wide accumulator to the signed logit range.
  function automatic logic signed [LOGIT_W-1:0] sat_logit(input logic signed [ACC_W-1:0] v);
    if (v > LOGIT_MAX_EXT) begin
      return LOGIT_MAX_EXT[LOGIT_W-1:0];
    end else if (v < LOGIT_MIN_EXT) begin
      return LOGIT_MIN_EXT[LOGIT_W-1:0];
    end
    return v[LOGIT_W-1:0];
  endfunction

endpackage

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - registered signed multiply-accumulate with bias load, accumulate and clear
module mac_unit
  import nn_pkg::*;
#(
  parameter int A_W      = DATA_W,
  parameter int B_W      = W_W,
  parameter int ACC_BITS = ACC_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                load,
  input  logic                accumulate,
  input  logic [ACC_BITS-1:0] load_val,
  input  logic [A_W-1:0]      a,
  input  logic [B_W-1:0]      b,
  output logic [ACC_BITS-1:0] acc
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0] prod;
  logic [ACC_BITS-1:0]   prod_ext;

  assign prod     = P_W'($signed(a)) * P_W'($signed(b));
  assign prod_ext = {{(ACC_BITS-P_W){prod[P_W-1]}}, prod};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (accumulate) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/dense_output_layer.sv
// rtl/dense_output_layer.sv - 32->10 fully-connected output layer with serial MAC, ROM weights and argmax
module dense_output_layer
  import nn_pkg::*;
#(
  parameter int N_IN  = N_HIDDEN,
  parameter int N_OUT = N_CLASSES,
  parameter logic [N_OUT*N_IN*W_W-1:0] W_INIT = '0,
  parameter logic [N_OUT*W_W-1:0]      B_INIT = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [N_IN*DATA_W-1:0]     layer_in,
  output logic [N_OUT*LOGIT_W-1:0]   logits,
  output logic [3:0]                 class_idx,
  output logic                       layer_done
);

  localparam int IW = $clog2(N_IN);
  localparam int JW = $clog2(N_OUT);
  localparam int AW = $clog2(N_OUT*N_IN);
  localparam logic [IW:0]   I_STORE = (IW+1)'(N_IN);
  localparam logic [JW-1:0] J_LAST  = JW'(N_OUT-1);

  state_t state, state_n;

  logic [IW:0]   i;
  logic [JW-1:0] j;
  logic [JW-1:0] k;

  logic [DATA_W-1:0]         x_mem     [N_IN];
  logic [W_W-1:0]            w_rom     [N_OUT*N_IN];
  logic [W_W-1:0]            b_rom     [N_OUT];
  logic signed [LOGIT_W-1:0] logit_mem [N_OUT];

  logic signed [LOGIT_W-1:0] best_val, nb_val, logit_k;
  logic [JW-1:0]             best_idx, nb_idx;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] bias_ext;
  logic [JW-1:0]    b_idx;
  logic [IW-1:0]    i_idx;
  logic [AW-1:0]    w_addr;

  logic capture, mac_load, mac_acc, mac_clear, store, argmax_step, finish, leave;

  for (genvar a = 0; a < N_OUT*N_IN; a++) begin : g_wrom
    assign w_rom[a] = W_INIT[a*W_W +: W_W];
  end

  for (genvar a = 0; a < N_OUT; a++) begin : g_brom
    assign b_rom[a] = B_INIT[a*W_W +: W_W];
    assign logits[a*LOGIT_W +: LOGIT_W] = logit_mem[a];
  end

  // ROM addresses come straight from the registered counters; at the store edge
  // i_idx wraps to 0, which keeps the address in range without affecting results.
  assign i_idx    = i[IW-1:0];
  assign w_addr   = AW'(int'(j) * N_IN + int'(i_idx));
  assign b_idx    = (state == S_IDLE || j == J_LAST) ? '0 : j + 1'b1;
  assign bias_ext = {{(ACC_W-W_W){b_rom[b_idx][W_W-1]}}, b_rom[b_idx]};

  mac_unit u_mac (
    .clk        (clk),
    .reset      (reset),
    .clear      (mac_clear),
    .load       (mac_load),
    .accumulate (mac_acc),
    .load_val   (bias_ext),
    .a          (x_mem[i_idx]),
    .b          (w_rom[w_addr]),
    .acc        (acc)
  );

  // Strict greater-than keeps the lowest index on ties; k==0 seeds the search.
  assign logit_k = logit_mem[k];

  always_comb begin
    nb_val = best_val;
    nb_idx = best_idx;
    if (k == '0 || logit_k > best_val) begin
      nb_val = logit_k;
      nb_idx = k;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    capture     = 1'b0;
    mac_load    = 1'b0;
    mac_acc     = 1'b0;
    mac_clear   = 1'b0;
    store       = 1'b0;
    argmax_step = 1'b0;
    finish      = 1'b0;
    leave       = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          capture  = 1'b1;
          mac_load = 1'b1;
          state_n  = S_MAC;
        end
      end
      S_MAC: begin
        if (i != I_STORE) begin
          mac_acc = 1'b1;
        end else begin
          store = 1'b1;
          if (j == J_LAST) begin
            mac_clear = 1'b1;
            state_n   = S_ARGMAX;
          end else begin
            mac_load = 1'b1;
          end
        end
      end
      S_ARGMAX: begin
        argmax_step = 1'b1;
        if (k == J_LAST) begin
          finish  = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (!enable) begin
          leave   = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i          <= '0;
      j          <= '0;
      k          <= '0;
      best_val   <= '0;
      best_idx   <= '0;
      class_idx  <= '0;
      layer_done <= 1'b0;
      for (int n = 0; n < N_IN; n++) begin
        x_mem[n] <= '0;
      end
      for (int n = 0; n < N_OUT; n++) begin
        logit_mem[n] <= '0;
      end
    end else begin
      if (capture) begin
        for (int n = 0; n < N_IN; n++) begin
          x_mem[n] <= layer_in[n*DATA_W +: DATA_W];
        end
        i <= '0;
        j <= '0;
      end
      if (mac_acc) begin
        i <= i + 1'b1;
      end
      if (store) begin
        logit_mem[j] <= sat_logit($signed(acc));
        i <= '0;
        j <= (j == J_LAST) ? '0 : j + 1'b1;
        k <= '0;
      end
      if (argmax_step) begin
        best_val <= nb_val;
        best_idx <= nb_idx;
        k        <= finish ? '0 : k + 1'b1;
      end
      if (finish) begin
        class_idx  <= 4'(nb_idx);
        layer_done <= 1'b1;
      end
      if (leave) begin
        layer_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dense_output_layer.sv
// tb/tb_dense_output_layer.sv - scoreboard bench for dense_output_layer over six fixed ROM images
module tb_dense_output_layer;

  localparam int N_IN  = 32;
  localparam int N_OUT = 10;
  localparam int DW    = 16;
  localparam int WW    = 16;
  localparam int LW    = 32;
  localparam int NI    = 6;
  localparam int XB    = N_IN*DW;
  localparam int LB    = N_OUT*LW;

  // Image 0: zero weights, bias j. 1: identity weights. 2: zero weights, bias 7.
  // 3: zero weights, bias 7 at 3 and 6. 4: all +32767. 5: all -32767.
  function automatic logic [N_OUT*N_IN*WW-1:0] mk_w(input int sel);
    logic [N_OUT*N_IN*WW-1:0] r;
    logic [WW-1:0] v;
    r = '0;
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) begin
        case (sel)
          1:       v = (i == j) ? 16'd1 : 16'd0;
          4:       v = 16'h7fff;
          5:       v = 16'h8001;
          default: v = 16'd0;
        endcase
        r[(j*N_IN+i)*WW +: WW] = v;
      end
    end
    return r;
  endfunction

  function automatic logic [N_OUT*WW-1:0] mk_b(input int sel);
    logic [N_OUT*WW-1:0] r;
    logic [WW-1:0] v;
    r = '0;
    for (int j = 0; j < N_OUT; j++) begin
      case (sel)
        0:       v = 16'(j);
        2:       v = 16'd7;
        3:       v = (j == 3 || j == 6) ? 16'd7 : 16'd0;
        default: v = 16'd0;
      endcase
      r[j*WW +: WW] = v;
    end
    return r;
  endfunction

  function automatic void model(input int sel, input logic [XB-1:0] xin,
                                output logic [LB-1:0] lg, output logic [3:0] cls);
    logic [N_OUT*N_IN*WW-1:0] w;
    logic [N_OUT*WW-1:0] b;
    logic signed [15:0] xv, wv, bv;
    logic signed [31:0] lv, best;
    longint acc;
    w = mk_w(sel);
    b = mk_b(sel);
    lg = '0;
    cls = '0;
    best = '0;
    for (int j = 0; j < N_OUT; j++) begin
      bv  = b[j*WW +: WW];
      acc = longint'(bv);
      for (int i = 0; i < N_IN; i++) begin
        xv  = xin[i*DW +: DW];
        wv  = w[(j*N_IN+i)*WW +: WW];
        acc = acc + longint'(xv) * longint'(wv);
      end
      if (acc > 64'sd2147483647)       lv = 32'h7fffffff;
      else if (acc < -64'sd2147483648) lv = 32'h80000000;
      else                             lv = 32'(acc);
      lg[j*LW +: LW] = lv;
      if (j == 0 || lv > best) begin
        best = lv;
        cls  = 4'(j);
      end
    end
  endfunction

  typedef struct {
    int             inst;
    logic [LB-1:0]  lg;
    logic [3:0]     cls;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic reset;
  logic [NI-1:0] en;
  logic [NI-1:0] done_o;
  logic [XB-1:0] layer_in;
  logic [LB-1:0] logits_o [NI];
  logic [3:0]    cls_o    [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dense_output_layer #(
      .N_IN   (N_IN),
      .N_OUT  (N_OUT),
      .W_INIT (mk_w(g)),
      .B_INIT (mk_b(g))
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (en[g]),
      .layer_in   (layer_in),
      .logits     (logits_o[g]),
      .class_idx  (cls_o[g]),
      .layer_done (done_o[g])
    );
  end

  task automatic start(input int inst, input logic [XB-1:0] xin);
    exp_t e;
    e.inst = inst;
    model(inst, xin, e.lg, e.cls);
    sb.push_back(e);
    @(negedge clk);
    layer_in = xin;
    en[inst] = 1'b1;
  endtask

  // Returns edges after the first counted edge until layer_done, or -1 on timeout.
  task automatic wait_done(input int inst, output int lat);
    lat = -1;
    for (int c = 1; c <= 1000; c++) begin
      @(posedge clk);
      #1;
      if (done_o[inst]) begin
        lat = c - 1;
        break;
      end
    end
  endtask

  task automatic rand_x(output logic [XB-1:0] xin);
    for (int n = 0; n < N_IN; n++) xin[n*DW +: DW] = 16'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en = '0;
    layer_in = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int n = 0; n < NI; n++) begin
      checks++; if (done_o[n] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d] got %b want 0", n, done_o[n]); end
      checks++; if (logits_o[n] !== '0) begin errors++; $display("FAIL reset_logits[%0d] got %h want 0", n, logits_o[n]); end
      checks++; if (cls_o[n] !== 4'd0) begin errors++; $display("FAIL reset_class[%0d] got %0d want 0", n, cls_o[n]); end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_bias_only();
    exp_t e; int lat; logic [XB-1:0] xin;
    rand_x(xin);
    start(0, xin);
    wait_done(0, lat);
    e = sb.pop_front();
    checks++; if (lat != 340) begin errors++; $display("FAIL bias_latency got %0d want 340", lat); end
    checks++; if (logits_o[0] !== e.lg) begin errors++; $display("FAIL bias_logits got %h want %h", logits_o[0], e.lg); end
    checks++; if (cls_o[0] !== e.cls) begin errors++; $display("FAIL bias_class got %0d want %0d", cls_o[0], e.cls); end
    @(negedge clk); en[0] = 1'b0;
    @(posedge clk); #1;
    checks++; if (done_o[0] !== 1'b0) begin errors++; $display("FAIL bias_done_drop got %b want 0", done_o[0]); end
    checks++; if (logits_o[0] !== e.lg) begin errors++; $display("FAIL bias_logits_hold got %h want %h", logits_o[0], e.lg); end
  endtask

  // Two runs separated by one enable-low edge; layer_in is scrambled after capture.
  task automatic test_back_to_back();
    exp_t e; int lat; logic [XB-1:0] xin;
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < N_IN; n++) xin[n*DW +: DW] = 16'(3*n);
      if (r == 1) xin[4*DW +: DW] = 16'd500;
      start(1, xin);
      @(posedge clk);
      @(negedge clk); layer_in = ~xin;
      wait_done(1, lat);
      if (lat >= 0) lat += 1;
      e = sb.pop_front();
      checks++; if (lat != 340) begin errors++; $display("FAIL ident_latency[%0d] got %0d want 340", r, lat); end
      checks++; if (logits_o[1] !== e.lg) begin errors++; $display("FAIL ident_logits[%0d] got %h want %h", r, logits_o[1], e.lg); end
      checks++; if (cls_o[1] !== e.cls) begin errors++; $display("FAIL ident_class[%0d] got %0d want %0d", r, cls_o[1], e.cls); end
      @(negedge clk); en[1] = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic test_ties();
    exp_t e; int lat; logic [XB-1:0] xin;
    for (int inst = 2; inst <= 3; inst++) begin
      rand_x(xin);
      start(inst, xin);
      wait_done(inst, lat);
      e = sb.pop_front();
      checks++; if (lat != 340) begin errors++; $display("FAIL tie_latency[%0d] got %0d want 340", inst, lat); end
      checks++; if (logits_o[inst] !== e.lg) begin errors++; $display("FAIL tie_logits[%0d] got %h want %h", inst, logits_o[inst], e.lg); end
      checks++; if (cls_o[inst] !== e.cls) begin errors++; $display("FAIL tie_class[%0d] got %0d want %0d", inst, cls_o[inst], e.cls); end
      @(negedge clk); en[inst] = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic test_saturation();
    exp_t e; int lat; logic [XB-1:0] xin; logic [LW-1:0] lim;
    for (int n = 0; n < N_IN; n++) xin[n*DW +: DW] = 16'h7fff;
    for (int inst = 4; inst <= 5; inst++) begin
      lim = (inst == 4) ? 32'h7fffffff : 32'h80000000;
      start(inst, xin);
      wait_done(inst, lat);
      e = sb.pop_front();
      checks++; if (lat != 340) begin errors++; $display("FAIL sat_latency[%0d] got %0d want 340", inst, lat); end
      checks++; if (logits_o[inst] !== e.lg) begin errors++; $display("FAIL sat_logits[%0d] got %h want %h", inst, logits_o[inst], e.lg); end
      checks++; if (logits_o[inst][LB-1 -: LW] !== lim) begin errors++; $display("FAIL sat_limit[%0d] got %h want %h", inst, logits_o[inst][LB-1 -: LW], lim); end
      checks++; if (cls_o[inst] !== e.cls) begin errors++; $display("FAIL sat_class[%0d] got %0d want %0d", inst, cls_o[inst], e.cls); end
      @(negedge clk); en[inst] = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e; int lat; logic [XB-1:0] xin;
    rand_x(xin);
    start(0, xin);
    repeat (100) @(posedge clk);
    @(negedge clk); reset = 1'b1; en[0] = 1'b0; sb.delete();
    @(posedge clk); #1;
    checks++; if (done_o[0] !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done_o[0]); end
    checks++; if (logits_o[0] !== '0) begin errors++; $display("FAIL midreset_logits got %h want 0", logits_o[0]); end
    checks++; if (cls_o[0] !== 4'd0) begin errors++; $display("FAIL midreset_class got %0d want 0", cls_o[0]); end
    @(negedge clk); reset = 1'b0;
    rand_x(xin);
    start(0, xin);
    wait_done(0, lat);
    e = sb.pop_front();
    checks++; if (lat != 340) begin errors++; $display("FAIL midreset_latency got %0d want 340", lat); end
    checks++; if (logits_o[0] !== e.lg) begin errors++; $display("FAIL midreset_logits_run got %h want %h", logits_o[0], e.lg); end
    checks++; if (cls_o[0] !== e.cls) begin errors++; $display("FAIL midreset_class_run got %0d want %0d", cls_o[0], e.cls); end
    @(negedge clk); en[0] = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_handshake();
    exp_t e; int lat; logic [XB-1:0] xin;
    rand_x(xin);
    start(1, xin);
    repeat (51) @(posedge clk);
    @(negedge clk); en[1] = 1'b0;
    wait_done(1, lat);
    if (lat >= 0) lat += 51;
    e = sb.pop_front();
    checks++; if (lat != 340) begin errors++; $display("FAIL drop_latency got %0d want 340", lat); end
    checks++; if (logits_o[1] !== e.lg) begin errors++; $display("FAIL drop_logits got %h want %h", logits_o[1], e.lg); end
    @(posedge clk); #1;
    checks++; if (done_o[1] !== 1'b0) begin errors++; $display("FAIL drop_pulse got %b want 0", done_o[1]); end
    repeat (5) @(posedge clk); #1;
    checks++; if (done_o[1] !== 1'b0 || cls_o[1] !== e.cls) begin errors++; $display("FAIL drop_idle done %b class %0d want 0 %0d", done_o[1], cls_o[1], e.cls); end

    rand_x(xin);
    start(0, xin);
    wait_done(0, lat);
    e = sb.pop_front();
    checks++; if (lat != 340) begin errors++; $display("FAIL hold_latency got %0d want 340", lat); end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (done_o[0] !== 1'b1 || logits_o[0] !== e.lg || cls_o[0] !== e.cls) begin
        errors++; $display("FAIL hold_stable cycle %0d done %b class %0d want 1 %0d", c, done_o[0], cls_o[0], e.cls);
      end
    end
    @(negedge clk); en[0] = 1'b0;
    @(posedge clk); #1;
    checks++; if (done_o[0] !== 1'b0) begin errors++; $display("FAIL hold_release got %b want 0", done_o[0]); end
  endtask

  initial begin
    reset = 1'b1;
    en = '0;
    layer_in = '0;
    test_reset();
    test_bias_only();
    test_back_to_back();
    test_ties();
    test_saturation();
    test_reset_mid_run();
    test_handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
